// File: rtl/layered_pixel_mux.sv
// Two-stage priority compositor for the VGA path: layered requests over a background, with
// colour-key transparency, frame-synchronous blinking and a frame-counted full-screen flash.
module layered_pixel_mux #(
   parameter int unsigned      NUM_LAYERS      = 6,
   parameter int unsigned      RGB_W           = 8,
   parameter logic [RGB_W-1:0] TRANSPARENT_KEY = 8'hFF,
   parameter int               BORDER_X        = 1,
   parameter int unsigned      BLINK_FRAMES    = 16,
   parameter logic [RGB_W-1:0] FLASH_RGB       = 8'hFF,
   parameter int unsigned      FLASH_FRAMES    = 8,
   parameter int unsigned      FLASH_COUNT     = 3,
   localparam int unsigned     HIT_W           = $clog2(NUM_LAYERS + 1)
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic                        startOfFrame,
   input  logic signed [10:0]          pixelX,
   input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
   input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
   input  logic [NUM_LAYERS-1:0]       layerEnable,
   input  logic [NUM_LAYERS-1:0]       blinkMask,
   input  logic [RGB_W-1:0]            BGRGB,
   input  logic                        flashTrigger,
   output logic [RGB_W-1:0]            RGBOut,
   output logic [HIT_W-1:0]            hitLayer,
   output logic                        flashActive
);

   localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned PHASE_W = $clog2(FLASH_FRAMES + 1);
   localparam int unsigned PAIR_W  = $clog2(FLASH_COUNT + 1);
   localparam logic signed [10:0] BORDER_S   = 11'(BORDER_X);
   localparam logic [HIT_W-1:0]   HIT_BG     = HIT_W'(NUM_LAYERS);

   typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;

   flash_state_t        flashState, flashState_d;
   logic                flashPending, flashPending_d;
   logic [PHASE_W-1:0]  phaseCnt, phaseCnt_d;
   logic [PAIR_W-1:0]   pairCnt, pairCnt_d;
   logic [BLINK_W-1:0]  blinkCnt;
   logic                blinkPhase;

   logic [NUM_LAYERS-1:0] effReq;
   logic [RGB_W-1:0]      winRGB;
   logic [HIT_W-1:0]      winHit;
   logic                  border;

   logic [RGB_W-1:0]      rgb1;
   logic [HIT_W-1:0]      hit1;
   logic                  border1;

   // Stage-1 selection: scan from lowest priority up so the lowest index wins.
   always_comb begin
      effReq = '0;
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
         effReq[i] = layerDrawingRequest[i] & layerEnable[i]
                   & (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT_KEY)
                   & ~(blinkMask[i] & ~blinkPhase);
      end
      winRGB = BGRGB;
      winHit = HIT_BG;
      for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
         if (effReq[i]) begin
            winRGB = layerRGB[i*RGB_W +: RGB_W];
            winHit = HIT_W'(i);
         end
      end
      border = (pixelX <= BORDER_S);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rgb1     <= '0;
         hit1     <= HIT_BG;
         border1  <= 1'b0;
         RGBOut   <= '0;
         hitLayer <= HIT_BG;
      end else begin
         rgb1     <= border ? '0 : winRGB;
         hit1     <= border ? HIT_BG : winHit;
         border1  <= border;
         RGBOut   <= (flashState == FLASH_ON && !border1) ? FLASH_RGB : rgb1;
         hitLayer <= hit1;
      end
   end

   // Blink phase only moves on a frame start so a frame never tears.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         blinkCnt   <= '0;
         blinkPhase <= 1'b1;
      end else if (startOfFrame) begin
         if (blinkCnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
         end else begin
            blinkCnt <= blinkCnt + BLINK_W'(1);
         end
      end
   end

   always_comb begin
      flashState_d   = flashState;
      flashPending_d = flashPending;
      phaseCnt_d     = phaseCnt;
      pairCnt_d      = pairCnt;
      unique case (flashState)
         IDLE: begin
            if (startOfFrame && (flashPending || flashTrigger)) begin
               flashState_d   = FLASH_ON;
               flashPending_d = 1'b0;
               phaseCnt_d     = '0;
               pairCnt_d      = '0;
            end else if (flashTrigger) begin
               flashPending_d = 1'b1;
            end
         end
         FLASH_ON: begin
            if (startOfFrame) begin
               if (phaseCnt == PHASE_W'(FLASH_FRAMES - 1)) begin
                  flashState_d = FLASH_OFF;
                  phaseCnt_d   = '0;
               end else begin
                  phaseCnt_d = phaseCnt + PHASE_W'(1);
               end
            end
         end
         FLASH_OFF: begin
            if (startOfFrame) begin
               if (phaseCnt == PHASE_W'(FLASH_FRAMES - 1)) begin
                  phaseCnt_d   = '0;
                  pairCnt_d    = pairCnt + PAIR_W'(1);
                  flashState_d = (pairCnt_d == PAIR_W'(FLASH_COUNT)) ? IDLE : FLASH_ON;
               end else begin
                  phaseCnt_d = phaseCnt + PHASE_W'(1);
               end
            end
         end
         default: flashState_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         flashState   <= IDLE;
         flashPending <= 1'b0;
         phaseCnt     <= '0;
         pairCnt      <= '0;
      end else begin
         flashState   <= flashState_d;
         flashPending <= flashPending_d;
         phaseCnt     <= phaseCnt_d;
         pairCnt      <= pairCnt_d;
      end
   end

   assign flashActive = (flashState != IDLE);

endmodule
